// File: rtl/led_matrix_scanner_if.sv
// Board-image and LED-drive bundle between the game side and the matrix scanner.
// The game side owns the image and control inputs; the scanner owns the drive outputs.
interface led_matrix_scanner_if;
  logic [63:0] mat;
  logic [1:0]  winner;
  logic        en;
  logic [7:0]  row_out;
  logic [7:0]  col_out;
  logic        frame_start;

  modport master (
    output mat, winner, en,
    input  row_out, col_out, frame_start
  );

  modport slave (
    input  mat, winner, en,
    output row_out, col_out, frame_start
  );
endinterface

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed 8x8 LED matrix scanner with per-frame snapshot, row blanking
// and a frame-rate blink while the game is over.
module led_matrix_scanner #(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  led_matrix_scanner_if.slave  bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END  = DIV_W'(BLANK_CYCLES);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [2:0]       r_row_idx;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_phase;
  logic [63:0]      r_snap;
  logic [7:0]       r_row_out;
  logic [7:0]       r_col_out;
  logic             r_frame_start;

  logic       w_at_frame;
  logic       w_div_wrap;
  logic       w_blank;
  logic       w_game_on;
  logic [7:0] w_row_data [8];
  logic [7:0] w_sel_cols;

  assign w_at_frame = (r_div_cnt == '0) && (r_row_idx == 3'd0);
  assign w_div_wrap = (r_div_cnt == DIV_LAST);
  assign w_blank    = (r_div_cnt < BLANK_END);
  assign w_game_on  = (bus.winner == 2'b11);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_row_slice
      assign w_row_data[gi] = r_snap[gi*8 +: 8];
    end
  endgenerate

  assign w_sel_cols = w_row_data[r_row_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_row_idx <= 3'd0;
    end else if (bus.en) begin
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_row_idx <= r_row_idx + 3'd1;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  // Snapshot once per frame so a frame never mixes old and new image data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (bus.en && w_at_frame) begin
      r_snap <= bus.mat;
    end
  end

  // Returning to play clears the blink immediately, even with the scan paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_game_on) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (bus.en && w_at_frame) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_out     <= 8'h00;
      r_col_out     <= 8'hFF;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= bus.en && w_at_frame;
      if (bus.en && !w_blank) begin
        r_row_out <= 8'h01 << r_row_idx;
        r_col_out <= r_blink_phase ? 8'hFF : w_sel_cols;
      end else begin
        r_row_out <= 8'h00;
        r_col_out <= 8'hFF;
      end
    end
  end

  assign bus.row_out     = r_row_out;
  assign bus.col_out     = r_col_out;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Randomised and directed bench for led_matrix_scanner against a frame-position
// reference model (one integer position per frame, blink derived from frame count).
module tb_led_matrix_scanner;

  localparam int CLK_DIV = 4;
  localparam int BLANK   = 1;
  localparam int BF      = 2;
  localparam int FRAME   = 8 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;

  led_matrix_scanner_if bus ();

  led_matrix_scanner #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position within the frame, frames seen while game over, snapshot.
  int          m_pos;
  int          m_go;
  logic [63:0] m_snap;
  logic [7:0]  e_row;
  logic [7:0]  e_col;
  logic        e_fs;
  logic [7:0]  prev_row = 8'h00;
  logic        m_ph;
  int          m_d;
  int          m_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos  = 0;
      m_go   = 0;
      m_snap = 64'hFFFF_FFFF_FFFF_FFFF;
      e_row  = 8'h00;
      e_col  = 8'hFF;
      e_fs   = 1'b0;
    end else begin
      m_ph = ((m_go / BF) % 2) == 1;
      m_d  = m_pos % CLK_DIV;
      m_r  = m_pos / CLK_DIV;
      if (!bus.en || m_d < BLANK) begin
        e_row = 8'h00;
        e_col = 8'hFF;
      end else begin
        e_row = 8'(1 << m_r);
        e_col = m_ph ? 8'hFF : m_snap[m_r*8 +: 8];
      end
      e_fs = bus.en && (m_pos == 0);
      if (bus.winner == 2'b11)
        m_go = 0;
      else if (bus.en && m_pos == 0)
        m_go++;
      if (bus.en && m_pos == 0)
        m_snap = bus.mat;
      if (bus.en)
        m_pos = (m_pos + 1) % FRAME;
    end
    #1;
    chk("row_out", 64'(bus.row_out), 64'(e_row));
    chk("col_out", 64'(bus.col_out), 64'(e_col));
    chk("frame_start", 64'(bus.frame_start), 64'(e_fs));
    chk("row_onehot0", 64'($onehot0(bus.row_out)), 64'd1);
    if (bus.row_out != 8'h00 && prev_row != 8'h00)
      chk("ghost_gap", 64'(bus.row_out), 64'(prev_row));
    prev_row = bus.row_out;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.frame_start === 1'b1) return;
    end
    chk("fs_timeout", 64'd0, 64'd1);
  endtask

  int c;

  initial begin
    bus.mat    = 64'hFFFF_FFFF_FFFF_FFFE;
    bus.winner = 2'b11;
    bus.en     = 1'b0;

    // Reset scan
    #2 rst = 1'b1;
    #1;
    chk("rst_row", 64'(bus.row_out), 64'h00);
    chk("rst_col", 64'(bus.col_out), 64'hFF);
    chk("rst_fs", 64'(bus.frame_start), 64'd0);
    cycles(3);
    rst    = 1'b0;
    bus.en = 1'b1;
    wait_fs(c);
    wait_fs(c);
    chk("fs_period", 64'(c), 64'(FRAME));
    wait_fs(c);
    chk("fs_period2", 64'(c), 64'(FRAME));

    // Tearing: new image at start of row 3 must wait for the next frame
    @(negedge clk);
    cycles(11);
    bus.mat = 64'h0;
    cycles(2 * FRAME);

    // Blink while game over, then resume play mid-frame
    cycles(5);
    bus.winner = 2'b01;
    cycles(8 * FRAME);
    cycles(7);
    bus.winner = 2'b11;
    cycles(FRAME);

    // Enable hold mid-row 5
    bus.mat = {$urandom, $urandom};
    wait_fs(c);
    @(negedge clk);
    cycles(21);
    bus.en = 1'b0;
    cycles(10);
    bus.en = 1'b1;
    wait_fs(c);
    chk("fs_after_hold", 64'(c), 64'(FRAME - 22 + 1));
    cycles(FRAME);

    // Asynchronous reset mid-row 6
    bus.mat = 64'h0;
    wait_fs(c);
    @(negedge clk);
    cycles(25);
    #2 rst = 1'b1;
    #1;
    chk("arst_row", 64'(bus.row_out), 64'h00);
    chk("arst_col", 64'(bus.col_out), 64'hFF);
    cycles(2);
    rst = 1'b0;
    cycles(2 * FRAME);

    // Random image, occasional game-over and enable drops
    repeat (3 * FRAME) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) bus.mat = {$urandom, $urandom};
      if ($urandom_range(0, 23) == 0)
        bus.winner = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      bus.en = ($urandom_range(0, 19) != 0);
    end
    bus.en = 1'b1;
    cycles(2 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Reads the 64-bit board image produced by the game control unit and drives a row-multiplexed 8x8 bicolour LED matrix.
- Scans one row at a time, with a blanking gap at each row change.
- Captures a full snapshot of the image once per frame so a frame never mixes old and new data.
- Blinks the whole display while the game is over, i.e. whenever winner != 2'b11.

Parameters:
- CLK_DIV, 1000: clk cycles per row slot. Must be >= 2.
- BLANK_CYCLES, 2: cycles at the start of each row slot during which the display is dark. Must satisfy 1 <= BLANK_CYCLES < CLK_DIV.
- BLINK_FRAMES, 32: number of frames per blink half-period while the game is over.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous reset, active-high.
- mat, input, 64: board image. Bit index = row*8 + col. 1 = LED off, 0 = LED on.
- winner, input, 2: 2'b11 = game in progress. Any other value = game over.
- en, input, 1: scan enable. When low, counters hold and the display is dark.
- row_out, output, 8: row drive, one-hot, active-high.
- col_out, output, 8: column drive, active-low. col_out[c] = 0 lights column c.
- frame_start, output, 1: one-cycle pulse at the start of each frame.

Behaviour:
- Reset (asynchronous, active-high). On assertion:
  - div_cnt=0, row_idx=0, blink_cnt=0, blink_phase=0.
  - snap=64'hFFFF_FFFF_FFFF_FFFF.
  - row_out=8'h00, col_out=8'hFF, frame_start=0.
- Counters. They advance only when en=1:
  - div_cnt counts 0..CLK_DIV-1 and then wraps to 0.
  - On the div_cnt wrap, row_idx increments mod 8.
  - A new frame begins at the edge where row_idx wraps 7->0.
- Snapshot: on every clock edge where en=1, div_cnt==0 and row_idx==0, load snap <= mat.
  - This includes the first enabled cycle after reset.
  - Changes to mat at any other time have no effect until the next frame.
- Outputs are registered and are functions of the counter state one cycle earlier:
  - Blanking: when div_cnt < BLANK_CYCLES, row_out=8'h00 and col_out=8'hFF.
  - Otherwise row_out = 8'h01 << row_idx, and col_out = snap[row_idx*8 +: 8] if blink_phase=0, or 8'hFF if blink_phase=1.
  - Because BLANK_CYCLES >= 1, a freshly loaded snap is never shown before its load completes.
- frame_start: high for exactly one cycle, in the output cycle that corresponds to the counter state div_cnt==0, row_idx==0 with en=1.
  - Period is 8*CLK_DIV cycles while en stays high.
- Blink:
  - Game over (winner != 2'b11): blink_cnt increments at each frame start. On reaching BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - Game in progress (winner == 2'b11): blink_cnt=0 and blink_phase=0 on the next clock, so the display is continuous.
  - winner is sampled every cycle and is not synchronised to frames. A return to 2'b11 clears the blink immediately, even mid-frame.
- en=0:
  - All counters, snap and blink state hold.
  - Outputs go to row_out=00 and col_out=FF on the next edge. frame_start=0.
  - When en returns to 1, scanning resumes from the held div_cnt/row_idx, with no frame restart.
- Reset mid-frame: outputs go dark immediately (asynchronous). After release, scanning restarts at row 0 and snap is reloaded from mat on the first enabled edge.
- Ghosting rule: row_out is never non-zero in the same cycle as the previous row's data. Across any row change the outputs pass through at least one cycle of row_out=00, col_out=FF.
- Each output bit changes at most once per clock. row_out is never multi-hot.

Test Plan (CLK_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2):
- Reset scan: rst pulse, en=1, mat=64'hFFFF_FFFF_FFFF_FFFE, winner=11.
  - Output repeats per row: 1 cycle of 00/FF, then 3 cycles with row_out=01<<r.
  - col_out=FE on row 0 and FF on all other rows.
  - frame_start pulses every 32 cycles.
- Tearing: change mat to all zeros at the start of row 3.
  - Rows 3-7 of the current frame still show the old data.
  - Every row shows col_out=00 from the next frame onward.
- Blink: winner=2'b01 held for 8 frames, mat=0.
  - Frames 0-1 lit (col_out=00), frames 2-3 dark (col_out=FF), frames 4-5 lit, and so on.
  - Set winner=11: the display is lit from the next cycle.
- Enable hold: drop en for 10 cycles mid-row 5.
  - Outputs are 00/FF during the hold.
  - On resume, row 5 completes its remaining cycles, with no frame_start until the row 7->0 wrap.
- Async reset mid-row 6, mat=0: row_out=00 and col_out=FF before the next clk edge. After release, row 0 is shown first, after 1 blank cycle.
- Ghosting check over 3 frames with random mat: the bench asserts that row_out is one-hot or zero every cycle, and that every row transition is preceded by a cycle with row_out=00.
